// File: rtl/uart_tx_peripheral_pkg.sv
// Shared encodings for the memory-mapped UART transmitter: FSM states and
// status word bit positions seen by CPU loads from the peripheral window.
package uart_tx_peripheral_pkg;

    typedef enum logic [1:0] {
        UART_STATE_IDLE  = 2'd0,
        UART_STATE_START = 2'd1,
        UART_STATE_DATA  = 2'd2,
        UART_STATE_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_STATUS_BUSY      = 0;
    localparam int UART_STATUS_FULL      = 1;
    localparam int UART_STATUS_OVERFLOW  = 2;
    localparam int UART_STATUS_COUNT_LSB = 4;
    localparam int UART_STATUS_COUNT_W   = 5;

    function automatic logic [31:0] uart_status_pack(
        input logic                           busy,
        input logic                           full,
        input logic                           overflow,
        input logic [UART_STATUS_COUNT_W-1:0] count
    );
        logic [31:0] word;
        word = '0;
        word[UART_STATUS_BUSY]     = busy;
        word[UART_STATUS_FULL]     = full;
        word[UART_STATUS_OVERFLOW] = overflow;
        word[UART_STATUS_COUNT_LSB +: UART_STATUS_COUNT_W] = count;
        return word;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous circular-buffer FIFO; a push while full is accepted only
// when a pop frees the slot in the same cycle.
module uart_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and count are control state.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: byte stores queue in a FIFO, the FSM
// serialises them back to back, and loads see a busy/full/overflow/count word.
module uart_tx_peripheral
    import uart_tx_peripheral_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [7:0]  write_data,
    input  logic        status_clear,
    output logic [31:0] status_data,
    output logic        tx
);

    localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

    uart_state_e       state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [2:0]        bit_idx, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              tx_next;
    logic              bit_end;
    logic              overflow;
    logic              overflow_set;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;

    uart_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (write_enable),
        .pop   (fifo_pop),
        .wdata (write_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end      = (baud_cnt == BAUD_LAST);
    assign overflow_set = write_enable && fifo_full && !fifo_pop;

    always_comb begin
        state_next = state;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;
        baud_next  = (state == UART_STATE_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        case (state)
            UART_STATE_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_rdata;
                    state_next = UART_STATE_START;
                end
            end
            UART_STATE_START: begin
                if (bit_end) begin
                    bit_next   = '0;
                    state_next = UART_STATE_DATA;
                end
            end
            UART_STATE_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    bit_next   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = UART_STATE_STOP;
                    end
                end
            end
            UART_STATE_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when work is queued.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_rdata;
                        state_next = UART_STATE_START;
                    end else begin
                        state_next = UART_STATE_IDLE;
                    end
                end
            end
            default: state_next = UART_STATE_IDLE;
        endcase
        case (state_next)
            UART_STATE_START: tx_next = 1'b0;
            UART_STATE_DATA:  tx_next = shift_next[0];
            default:          tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= UART_STATE_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            tx       <= tx_next;
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (status_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        shift_reg <= shift_next;
    end

    assign status_data = uart_status_pack((state != UART_STATE_IDLE) || (fifo_count != '0),
                                          fifo_full, overflow,
                                          UART_STATUS_COUNT_W'(fifo_count));

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Scoreboarded bench for uart_tx_peripheral: accepted bytes are queued as
// expected frames and a line monitor decodes tx and pops/compares them.
`timescale 1ns/1ps
module tb_uart_tx_peripheral;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        write_enable = 1'b0;
    logic [7:0]  write_data = 8'h00;
    logic        status_clear = 1'b0;
    logic [31:0] status_data;
    logic        tx;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          frames_rx = 0;
    logic [7:0]  exp_q[$];
    int          frame_starts[$];

    uart_tx_peripheral #(
        .CLOCKS_PER_BIT (CPB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_data   (write_data),
        .status_clear (status_clear),
        .status_data  (status_data),
        .tx           (tx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic write_byte(input logic [7:0] b, input bit expect_tx);
        write_enable = 1'b1;
        write_data   = b;
        @(negedge clock);
        write_enable = 1'b0;
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (3) @(negedge clock);
    endtask

    // Line monitor: every bit must hold for CPB cycles; byte checked against scoreboard.
    initial begin : monitor
        logic [9:0]  bits;
        bit          glitch;
        bit          aborted;
        int          start_c;
        logic [31:0] exp;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && tx === 1'b0) begin
                start_c = cyc;
                glitch  = 1'b0;
                aborted = 1'b0;
                bits    = '0;
                for (int i = 0; i < 10 * CPB; i++) begin
                    if (i != 0) @(negedge clock);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % CPB == 0) bits[i / CPB] = tx;
                    else if (tx !== bits[i / CPB]) glitch = 1'b1;
                end
                if (!aborted) begin
                    frames_rx++;
                    frame_starts.push_back(start_c);
                    if (exp_q.size() > 0) exp = {24'h0, exp_q.pop_front()};
                    else exp = 32'hDEAD;
                    check_eq("frame_byte", {24'h0, bits[8:1]}, exp);
                    check_eq("frame_shape", {29'h0, glitch, bits[0], bits[9]}, 32'h1);
                end
            end
        end
    end

    initial begin : stimulus
        logic [9:0] pat;
        bit         saw_low;
        int         frames_before;

        // Reset held: inputs toggle, nothing may move.
        repeat (6) begin
            @(negedge clock);
            write_enable = 1'($urandom);
            write_data   = 8'($urandom);
            status_clear = 1'($urandom);
            #1;
            check_eq("rst_tx", {31'h0, tx}, 32'h1);
            check_eq("rst_status", status_data, 32'h0);
        end
        @(negedge clock);
        write_enable = 1'b0;
        status_clear = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check_eq("post_rel_status", status_data, 32'h0);
        check_eq("post_rel_tx", {31'h0, tx}, 32'h1);
        check_eq("post_rel_frames", frames_rx, 0);

        // Single byte: exact waveform and busy timing.
        write_byte(8'hA5, 1'b1);
        check_eq("a5_count1", status_data, 32'h11);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clock);
            check_eq($sformatf("a5_tx%0d", i), {31'h0, tx}, {31'h0, pat[i / CPB]});
            if (i == 0)  check_eq("a5_popped", status_data, 32'h1);
            if (i == 39) check_eq("a5_busy_end", status_data, 32'h1);
        end
        @(negedge clock);
        check_eq("a5_idle_status", status_data, 32'h0);
        check_eq("a5_idle_tx", {31'h0, tx}, 32'h1);
        wait_drain(100);

        // Back-to-back 00 then FF.
        frame_starts.delete();
        write_enable = 1'b1;
        write_data   = 8'h00;
        @(negedge clock);
        exp_q.push_back(8'h00);
        write_data = 8'hFF;
        check_eq("b2b_count_a", status_data, 32'h11);
        @(negedge clock);
        write_enable = 1'b0;
        exp_q.push_back(8'hFF);
        check_eq("b2b_count_b", status_data, 32'h11);
        wait_drain(200);
        check_eq("b2b_frames", frame_starts.size(), 2);
        if (frame_starts.size() == 2)
            check_eq("b2b_gap", frame_starts[1] - frame_starts[0], 10 * CPB);
        check_eq("b2b_idle", status_data, 32'h0);

        // Overflow, clear, then full write coincident with the stop-end pop.
        frame_starts.delete();
        write_byte(8'h77, 1'b1);
        repeat (3) @(negedge clock);
        for (int k = 1; k <= 5; k++) write_byte(8'(k), k <= 4);
        check_eq("ovf_status", status_data, 32'h47);
        status_clear = 1'b1;
        @(negedge clock);
        status_clear = 1'b0;
        check_eq("ovf_cleared", status_data, 32'h43);
        repeat (31) @(negedge clock);
        check_eq("full_prepop", status_data, 32'h43);
        write_byte(8'h99, 1'b1);
        check_eq("full_pop_push", status_data, 32'h43);
        wait_drain(400);
        check_eq("ovf_frames", frame_starts.size(), 6);
        if (frame_starts.size() == 6)
            for (int k = 1; k < 6; k++)
                check_eq($sformatf("ovf_gap%0d", k), frame_starts[k] - frame_starts[k-1], 10 * CPB);
        check_eq("ovf_idle", status_data, 32'h0);

        // Reset mid-DATA of 3C with two bytes queued.
        write_byte(8'h3C, 1'b0);
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        check_eq("rst_mid_queued", status_data, 32'h21);
        repeat (10) @(negedge clock);
        frames_before = frames_rx;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_mid_tx", {31'h0, tx}, 32'h1);
        check_eq("rst_mid_status", status_data, 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        saw_low = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check_eq("rst_no_resume", {31'h0, saw_low}, 32'h0);
        check_eq("rst_no_frames", frames_rx, frames_before);
        check_eq("rst_final_status", status_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_peripheral.md
# uart_tx_peripheral

Memory-mapped UART transmitter on the CPU's output-peripheral side: consumes byte writes from the memory controller's peripheral address space and serialises them as 8N1 frames onto one output pin. It buffers writes in a small FIFO so a store never stalls the pipeline, and returns a status word for loads from the same peripheral window.

## Interface
Parameters:
- `CLOCKS_PER_BIT`, 4, cpu_clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 4, byte entries; power of two, 2..16.

Ports:
- `clock` in 1: cpu_clock domain, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `write_enable` in 1: one-cycle strobe, data-register store decoded by memory_controller.
- `write_data` in 8: byte to transmit, sampled when `write_enable`=1.
- `status_clear` in 1: one-cycle strobe; clears the overflow flag.
- `status_data` out 32: bit0 busy, bit1 full, bit2 overflow, bits[8:4] fifo count, other bits 0.
- `tx` out 1: serial line, idle high.

## Operation
- FIFO: circular buffer, write/read pointers wrap modulo `FIFO_DEPTH`, count 0..`FIFO_DEPTH`.
- Write when count < `FIFO_DEPTH`: byte stored, count +1.
- Write when full and no pop in the same cycle: byte dropped, overflow set (sticky).
- Write when full with a pop in the same cycle: accepted, count unchanged, overflow not set.
- `status_clear` and an overflow-setting write in the same cycle: overflow ends set (set wins).
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If FIFO non-empty, pop into shift register, go to START.
  - START: `tx`=0 for `CLOCKS_PER_BIT` cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first, `CLOCKS_PER_BIT` cycles per bit. Shift right and increment index each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLOCKS_PER_BIT` cycles. At the end: if FIFO non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Baud counter: `$clog2(CLOCKS_PER_BIT)` bits, reloads to 0 at every bit boundary.
- busy = (state != IDLE) || (count != 0).
- full = (count == `FIFO_DEPTH`).

## Timing
- Reset values: `tx`=1, state IDLE, count 0, pointers 0, overflow 0, `status_data`=0.
- `status_data` is registered state only; it reflects writes from the edge after the write.
- Latency, idle and empty: write at edge N makes count 1. Pop at edge N+1; `tx` falls after edge N+1 and count returns to 0.
- Frame length: exactly 10·`CLOCKS_PER_BIT` cycles. Queued frames are contiguous.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous), FIFO contents discarded, no partial frame resumes after release.
- First edge after reset release: no pop occurs unless a write has landed.

## Structure
- Shared constants header, alongside the existing `DATA_SOURCE_*` defines:
  - `UART_STATE_IDLE/START/DATA/STOP` 2-bit encodings.
  - `UART_STATUS_BUSY/FULL/OVERFLOW` bit positions.
  - `UART_STATUS_COUNT_LSB`.
- Sub-module `uart_fifo`: parameterised sync FIFO with push/pop/full/empty/count.
- Top-level `uart_tx_peripheral` holds the FSM, baud counter and status register.

## Test plan
- Reset: hold `reset`=0, toggle inputs -> `tx`=1, `status_data`=32'h0. Release -> unchanged until a write.
- Single byte, `CLOCKS_PER_BIT`=4, write 8'hA5 at edge N -> `tx` from N+1 is 0×4, then 1,0,1,0,0,1,0,1 each ×4, then 1×4. busy drops after 40 cycles of frame.
- Back-to-back: write 8'h00 then 8'hFF on consecutive cycles -> two frames with no idle cycle between stop and second start. count peaks at 1, not 2, because the first byte is popped the cycle after its write.
- Overflow: hold FSM busy, write 5 bytes 8'h01..8'h05 -> full=1, count=4, overflow=1, 8'h05 never transmitted. `status_clear` -> overflow=0.
- Full with simultaneous pop: FIFO full, write coincident with the stop-end pop -> byte accepted, count stays 4, overflow stays 0.
- Reset mid-DATA of 8'h3C with 2 bytes queued -> `tx`=1 immediately, count 0. After release, no further frames appear.
